pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//   Sequences the 5-stage pipeline around the instruction decode stage.
//   Detects load-use hazards, data-memory busy and branch mispredicts, and
//   drives IF/ID/EX stall, bubble and flush controls plus the PC redirect.
//   Sits beside the decode stage; consumes ID and EX stage fields; feeds the
//   fetch PC mux and the pipeline registers.
// PARAMETERS
//   PC_WIDTH        14  program counter / target address width
//   REG_IDX_WIDTH    5  register index width; index 0 is hardwired zero
//   LOAD_USE_CYCLES  2  stall cycles per load-use hazard (>=1)
//   FLUSH_CYCLES     2  cycles flush_if_id is held after a mispredict (>=1)
//   CNT_WIDTH       16  performance counter width
// PORTS
//   clk                     in   1          pipeline clock, rising edge
//   rst                     in   1          async reset, active-high
//   id_valid                in   1          ID holds a real instruction
//   reg1_index_id           in   REG_IDX    source 1 index in ID
//   reg2_index_id           in   REG_IDX    source 2 index in ID
//   uses_reg1_id            in   1          ID instruction reads source 1
//   uses_reg2_id            in   1          ID instruction reads source 2
//   ex_valid                in   1          EX holds a real instruction
//   ex_mem_read             in   1          EX instruction is a load
//   dest_reg_index_ex       in   REG_IDX    EX destination index
//   branch_resolved_ex      in   1          EX resolved a branch this cycle
//   branch_taken_ex         in   1          resolved direction
//   branch_prediction_ex    in   1          prediction carried from ID
//   target_address_ex       in   PC_WIDTH   branch target
//   next_program_counter_ex in   PC_WIDTH   fall-through PC
//   mem_busy                in   1          data memory not ready
//   stall_if                out  1          hold PC and IF/ID register
//   stall_id                out  1          hold ID/EX register inputs
//   stall_ex                out  1          hold EX/MEM register
//   bubble_ex               out  1          inject NOP into ID/EX
//   flush_if_id             out  1          clear IF/ID register
//   flush_id_ex             out  1          clear ID/EX register
//   redirect_valid          out  1          load PC from redirect_pc
//   redirect_pc             out  PC_WIDTH   corrected fetch address
//   mispredict_count        out  CNT_WIDTH  accepted mispredicts, saturating
//   stall_count             out  CNT_WIDTH  cycles with stall_if=1, saturating
//   state                   out  2          FSM state, for debug
// BEHAVIOUR
//   - rst high: state=RUN, counters and internal counters = 0; all outputs 0
//     immediately (async), including mid-stall or mid-flush.
//   - Control outputs: combinational from state and inputs, same cycle.
//     State, counters and perf counters: registered.
//   - mispredict = branch_resolved_ex & (branch_taken_ex != branch_prediction_ex).
//   - load_use = id_valid & ex_valid & ex_mem_read & dest_reg_index_ex!=0 &
//     ((uses_reg1_id & reg1==dest) | (uses_reg2_id & reg2==dest)).
//   - Priority in RUN: mispredict > mem_busy > load_use.
//   - RUN(0): mispredict -> redirect_valid=1,
//     redirect_pc = taken ? target_address_ex : next_program_counter_ex;
//     flush_if_id=flush_id_ex=1; mispredict_count++; if FLUSH_CYCLES>1 go
//     FLUSH with cnt=FLUSH_CYCLES-1. mem_busy -> stall_if/id/ex=1, go
//     MEM_WAIT. load_use -> stall_if=stall_id=bubble_ex=1; if
//     LOAD_USE_CYCLES>1 go LOAD_STALL with cnt=LOAD_USE_CYCLES-1.
//   - LOAD_STALL(1): stall_if=stall_id=bubble_ex=1; cnt--; at cnt==1 ->
//     RUN. branch_resolved_ex ignored. mem_busy adds stall_ex=1 and freezes cnt.
//   - MEM_WAIT(2): stall_if/id/ex=1 while mem_busy; in the first cycle with
//     mem_busy=0 all stalls 0 and -> RUN. Branch inputs ignored.
//   - FLUSH(3): flush_if_id=1, redirect_valid=0, branch inputs ignored;
//     cnt-- only when mem_busy=0 (mem_busy also drives stall_if/id/ex);
//     at cnt==1 with mem_busy=0 -> RUN.
//   - Counters saturate at all-ones; no wrap.
// TESTING
//   1 Load-use: ex load dest=3, ID reg1=3 uses_reg1=1 -> stall_if/id,
//     bubble_ex high exactly 2 cycles; stall_count=2.
//   2 Index 0: ex load dest=0, ID reg1=0 -> no stall.
//   3 Mispredict: predicted 0, taken 1, target=0x0123 -> same cycle
//     redirect_valid=1, redirect_pc=0x0123, flush_if_id 2 cycles,
//     mispredict_count=1.
//   4 Simultaneous mispredict+mem_busy+load_use in RUN -> mispredict wins,
//     then FLUSH extends while mem_busy=1 (3 busy cycles -> flush 5 cycles).
//   5 MEM_WAIT: mem_busy 4 cycles -> stall_if/id/ex 4 cycles, 0 on 5th, state=RUN.
//   6 rst pulsed mid-LOAD_STALL -> outputs 0 at once, state=0, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer beside the decode stage: load-use stalls, data-memory wait,
// branch-mispredict flush/redirect, and saturating performance counters.
module pipeline_hazard_controller #(
    parameter int PC_WIDTH        = 14,
    parameter int REG_IDX_WIDTH   = 5,
    parameter int LOAD_USE_CYCLES = 2,
    parameter int FLUSH_CYCLES    = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [REG_IDX_WIDTH-1:0] reg1_index_id,
    input  logic [REG_IDX_WIDTH-1:0] reg2_index_id,
    input  logic                     uses_reg1_id,
    input  logic                     uses_reg2_id,
    input  logic                     ex_valid,
    input  logic                     ex_mem_read,
    input  logic [REG_IDX_WIDTH-1:0] dest_reg_index_ex,
    input  logic                     branch_resolved_ex,
    input  logic                     branch_taken_ex,
    input  logic                     branch_prediction_ex,
    input  logic [PC_WIDTH-1:0]      target_address_ex,
    input  logic [PC_WIDTH-1:0]      next_program_counter_ex,
    input  logic                     mem_busy,
    output logic                     stall_if,
    output logic                     stall_id,
    output logic                     stall_ex,
    output logic                     bubble_ex,
    output logic                     flush_if_id,
    output logic                     flush_id_ex,
    output logic                     redirect_valid,
    output logic [PC_WIDTH-1:0]      redirect_pc,
    output logic [CNT_WIDTH-1:0]     mispredict_count,
    output logic [CNT_WIDTH-1:0]     stall_count,
    output logic [1:0]               state
);

    localparam int MAX_CYC = (LOAD_USE_CYCLES > FLUSH_CYCLES) ? LOAD_USE_CYCLES : FLUSH_CYCLES;
    localparam int CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mispredict, load_use, count_mispredict;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign mispredict = branch_resolved_ex & (branch_taken_ex != branch_prediction_ex);
    assign load_use   = id_valid & ex_valid & ex_mem_read & (dest_reg_index_ex != '0) &
                        ((uses_reg1_id & (reg1_index_id == dest_reg_index_ex)) |
                         (uses_reg2_id & (reg2_index_id == dest_reg_index_ex)));

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        count_mispredict = 1'b0;
        stall_if         = 1'b0;
        stall_id         = 1'b0;
        stall_ex         = 1'b0;
        bubble_ex        = 1'b0;
        flush_if_id      = 1'b0;
        flush_id_ex      = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;

        unique case (state_q)
            RUN: begin
                if (mispredict) begin
                    redirect_valid   = 1'b1;
                    redirect_pc      = branch_taken_ex ? target_address_ex : next_program_counter_ex;
                    flush_if_id      = 1'b1;
                    flush_id_ex      = 1'b1;
                    count_mispredict = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = CW'(FLUSH_CYCLES - 1);
                    end
                end else if (mem_busy) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                    state_d  = MEM_WAIT;
                end else if (load_use) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    if (LOAD_USE_CYCLES > 1) begin
                        state_d = LOAD_STALL;
                        cnt_d   = CW'(LOAD_USE_CYCLES - 1);
                    end
                end
            end
            LOAD_STALL: begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
                // A busy memory holds the whole stall window where it is.
                if (mem_busy) begin
                    stall_ex = 1'b1;
                end else if (cnt_q == CW'(1)) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                flush_if_id = 1'b1;
                if (mem_busy) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                end else if (cnt_q == CW'(1)) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = RUN;
        endcase

        // Reset forces every control output low without waiting for a clock.
        if (rst) begin
            stall_if       = 1'b0;
            stall_id       = 1'b0;
            stall_ex       = 1'b0;
            bubble_ex      = 1'b0;
            flush_if_id    = 1'b0;
            flush_id_ex    = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= RUN;
            cnt_q            <= '0;
            mispredict_count <= '0;
            stall_count      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (count_mispredict) mispredict_count <= sat_inc(mispredict_count);
            if (stall_if)         stall_count      <= sat_inc(stall_count);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: per-cycle expected controls
// are queued as stimulus is driven and compared on the falling edge.
module tb_pipeline_hazard_controller;

    localparam int PCW = 14;
    localparam int RW  = 5;
    localparam int CW  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           id_valid, uses_reg1_id, uses_reg2_id;
    logic [RW-1:0]  reg1_index_id, reg2_index_id, dest_reg_index_ex;
    logic           ex_valid, ex_mem_read;
    logic           branch_resolved_ex, branch_taken_ex, branch_prediction_ex;
    logic [PCW-1:0] target_address_ex, next_program_counter_ex;
    logic           mem_busy;
    logic           stall_if, stall_id, stall_ex, bubble_ex;
    logic           flush_if_id, flush_id_ex, redirect_valid;
    logic [PCW-1:0] redirect_pc;
    logic [CW-1:0]  mispredict_count, stall_count;
    logic [1:0]     state;

    pipeline_hazard_controller dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .reg1_index_id(reg1_index_id), .reg2_index_id(reg2_index_id),
        .uses_reg1_id(uses_reg1_id), .uses_reg2_id(uses_reg2_id),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .dest_reg_index_ex(dest_reg_index_ex),
        .branch_resolved_ex(branch_resolved_ex), .branch_taken_ex(branch_taken_ex),
        .branch_prediction_ex(branch_prediction_ex), .target_address_ex(target_address_ex),
        .next_program_counter_ex(next_program_counter_ex), .mem_busy(mem_busy),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .bubble_ex(bubble_ex),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mispredict_count(mispredict_count), .stall_count(stall_count), .state(state)
    );

    always #5 clk = ~clk;

    // Control vector order: stall_if stall_id stall_ex bubble_ex flush_if_id flush_id_ex redirect_valid
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_LOAD  = 7'b1101000;
    localparam logic [6:0] C_LOADB = 7'b1111000;
    localparam logic [6:0] C_MEM   = 7'b1110000;
    localparam logic [6:0] C_MISP  = 7'b0000111;
    localparam logic [6:0] C_FL    = 7'b0000100;
    localparam logic [6:0] C_FLB   = 7'b1110100;

    typedef struct {
        string          tag;
        logic [6:0]     ctrl;
        logic [PCW-1:0] pc;
        logic [1:0]     st;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {stall_if, stall_id, stall_ex, bubble_ex, flush_if_id, flush_id_ex, redirect_valid};
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_val({e.tag, "_ctrl"},  32'(ctrl_vec()),  32'(e.ctrl));
            check_val({e.tag, "_pc"},    32'(redirect_pc), 32'(e.pc));
            check_val({e.tag, "_state"}, 32'(state),       32'(e.st));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input string tag, input logic [6:0] ctrl,
                              input logic [PCW-1:0] pc, input logic [1:0] st);
        exp_t e;
        e.tag = tag; e.ctrl = ctrl; e.pc = pc; e.st = st;
        sb.push_back(e);
    endtask

    task automatic set_idle();
        id_valid = 0; uses_reg1_id = 0; uses_reg2_id = 0;
        reg1_index_id = '0; reg2_index_id = '0; dest_reg_index_ex = '0;
        ex_valid = 0; ex_mem_read = 0;
        branch_resolved_ex = 0; branch_taken_ex = 0; branch_prediction_ex = 0;
        target_address_ex = '0; next_program_counter_ex = '0;
        mem_busy = 0;
    endtask

    task automatic set_load_use(input logic [RW-1:0] dest, input logic [RW-1:0] r1,
                                input logic u1, input logic [RW-1:0] r2, input logic u2);
        id_valid = 1; ex_valid = 1; ex_mem_read = 1;
        dest_reg_index_ex = dest;
        reg1_index_id = r1; uses_reg1_id = u1;
        reg2_index_id = r2; uses_reg2_id = u2;
    endtask

    task automatic set_branch(input logic taken, input logic pred);
        branch_resolved_ex = 1; branch_taken_ex = taken; branch_prediction_ex = pred;
        target_address_ex = 14'h0123; next_program_counter_ex = 14'h0200;
    endtask

    initial begin
        rst = 1;
        set_idle();
        #1;
        check_val("rst_ctrl",   32'(ctrl_vec()), 32'(C_NONE));
        check_val("rst_state",  32'(state), 0);
        check_val("rst_scount", 32'(stall_count), 0);
        check_val("rst_mcount", 32'(mispredict_count), 0);
        @(negedge clk);
        rst = 0;

        // Load-use on source 1: exactly two stall cycles
        cyc(); set_load_use(5'd3, 5'd3, 1, 5'd0, 0); expect_cyc("lu1_c0", C_LOAD, '0, 2'd0);
        cyc(); ex_valid = 0;                          expect_cyc("lu1_c1", C_LOAD, '0, 2'd1);
        cyc();                                        expect_cyc("lu1_c2", C_NONE, '0, 2'd0);
        check_val("lu1_stall_count", 32'(stall_count), 2);

        // Destination index 0 never stalls
        cyc(); set_idle(); set_load_use(5'd0, 5'd0, 1, 5'd0, 1); expect_cyc("idx0", C_NONE, '0, 2'd0);

        // Load-use on source 2, memory busy during the stall freezes the window
        cyc(); set_idle(); set_load_use(5'd7, 5'd1, 1, 5'd7, 1); expect_cyc("lu2_c0", C_LOAD, '0, 2'd0);
        cyc(); set_idle(); mem_busy = 1;                         expect_cyc("lu2_busy", C_LOADB, '0, 2'd1);
        cyc(); mem_busy = 0;                                     expect_cyc("lu2_c1", C_LOAD, '0, 2'd1);
        cyc();                                                   expect_cyc("lu2_c2", C_NONE, '0, 2'd0);
        check_val("lu2_stall_count", 32'(stall_count), 5);

        // Taken mispredict: redirect to target, flush two cycles
        cyc(); set_branch(1, 0);           expect_cyc("mp_t_c0", C_MISP, 14'h0123, 2'd0);
        cyc(); set_branch(0, 1);           expect_cyc("mp_t_c1", C_FL, '0, 2'd3);
        cyc(); set_idle();                 expect_cyc("mp_t_c2", C_NONE, '0, 2'd0);
        check_val("mp_t_count", 32'(mispredict_count), 1);

        // Not-taken mispredict redirects to fall-through; a correct prediction does nothing
        cyc(); set_branch(0, 1);           expect_cyc("mp_nt_c0", C_MISP, 14'h0200, 2'd0);
        cyc(); set_idle();                 expect_cyc("mp_nt_c1", C_FL, '0, 2'd3);
        cyc(); set_branch(1, 1);           expect_cyc("bp_ok", C_NONE, '0, 2'd0);
        cyc(); set_idle();
        check_val("mp_nt_count", 32'(mispredict_count), 2);

        // Mispredict + mem_busy + load_use together: mispredict wins, flush stretches
        cyc(); set_load_use(5'd4, 5'd4, 1, 5'd0, 0); set_branch(1, 0); mem_busy = 1;
                                           expect_cyc("pri_c0", C_MISP, 14'h0123, 2'd0);
        cyc(); set_idle(); mem_busy = 1;   expect_cyc("pri_c1", C_FLB, '0, 2'd3);
        cyc();                             expect_cyc("pri_c2", C_FLB, '0, 2'd3);
        cyc();                             expect_cyc("pri_c3", C_FLB, '0, 2'd3);
        cyc(); mem_busy = 0;               expect_cyc("pri_c4", C_FL, '0, 2'd3);
        cyc();                             expect_cyc("pri_c5", C_NONE, '0, 2'd0);
        check_val("pri_mcount", 32'(mispredict_count), 3);
        check_val("pri_scount", 32'(stall_count), 8);

        // Memory wait for four cycles, branch ignored while waiting
        cyc(); mem_busy = 1;               expect_cyc("mw_c0", C_MEM, '0, 2'd0);
        cyc();                             expect_cyc("mw_c1", C_MEM, '0, 2'd2);
        cyc(); set_branch(1, 0);           expect_cyc("mw_c2", C_MEM, '0, 2'd2);
        cyc(); branch_resolved_ex = 0;     expect_cyc("mw_c3", C_MEM, '0, 2'd2);
        cyc(); mem_busy = 0;               expect_cyc("mw_c4", C_NONE, '0, 2'd2);
        cyc(); set_idle();                 expect_cyc("mw_c5", C_NONE, '0, 2'd0);
        check_val("mw_scount", 32'(stall_count), 12);
        check_val("mw_mcount", 32'(mispredict_count), 3);

        // Asynchronous reset in the middle of a load stall
        cyc(); set_load_use(5'd9, 5'd9, 1, 5'd0, 0); expect_cyc("ar_c0", C_LOAD, '0, 2'd0);
        cyc();
        check_val("ar_pre_state", 32'(state), 1);
        check_val("ar_pre_ctrl",  32'(ctrl_vec()), 32'(C_LOAD));
        #1 rst = 1;
        #1;
        check_val("ar_ctrl",   32'(ctrl_vec()), 32'(C_NONE));
        check_val("ar_state",  32'(state), 0);
        check_val("ar_scount", 32'(stall_count), 0);
        check_val("ar_mcount", 32'(mispredict_count), 0);
        set_idle();
        #1 rst = 0;

        repeat (2) @(posedge clk);
        check_val("sb_drain", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
